// File: rtl/sram_controller_gen_pkg.sv
// sram_controller_gen_pkg: FSM state encodings and default parameters for the SRAM controller
package sram_controller_gen_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SRAM_DW     = 16;
    localparam int DEF_SRAM_AW     = 18;
    localparam int DEF_BASE_ADDR   = 1024;
    localparam int DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/sram_controller_gen_beat_timer.sv
// sram_beat_timer: loadable down-counter flagging the last strobe cycle of a beat
module sram_beat_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (load) cnt <= CW'(WAIT_CYCLES - 1);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign last = cnt == '0;
endmodule

// File: rtl/sram_controller_gen.sv
// sram_controller_gen: splits a DATA_W word into SRAM_DW beats on an async SRAM
// Optional posted-write buffer enabled by defining SRAM_CTRL_POSTED_WRITE_EN.
module sram_controller_gen
    import sram_controller_gen_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SRAM_DW     = DEF_SRAM_DW,
    parameter int SRAM_AW     = DEF_SRAM_AW,
    parameter int BASE_ADDR   = DEF_BASE_ADDR,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_W_EN,
    input  logic                  MEM_R_EN,
    input  logic [31:0]           address,
    input  logic [DATA_W-1:0]     writeData,
    input  logic [DATA_W/8-1:0]   byteEn,
    output logic                  ready,
    output logic [DATA_W-1:0]     readData,
    output logic [SRAM_AW-1:0]    SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]    SRAM_DQ,
    output logic                  SRAM_UB_N,
    output logic                  SRAM_LB_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N
);
    localparam int BEATS = DATA_W / SRAM_DW;
    localparam int LANES = SRAM_DW / 8;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFS   = $clog2(DATA_W / 8);
    logic [2:0]          state;
    logic [BW-1:0]       beat;
    logic                wr;
    logic [31:0]         waddr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   rbuf;
    logic                last;
    logic                active;
    logic                req;
    logic [LANES-1:0]    lane;
    assign req    = MEM_W_EN | MEM_R_EN;
    assign active = state == S_SETUP || state == S_STROBE || state == S_HOLD;
    assign lane   = be[beat*LANES +: LANES];
    sram_beat_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_SETUP),
        .en   (state == S_STROBE),
        .last (last)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= S_IDLE;
            beat     <= '0;
            wr       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            be       <= '0;
            rbuf     <= '0;
            readData <= '0;
        end else begin
            case (state)
                S_IDLE:
                    if (req) begin
                        state <= S_SETUP;
                        beat  <= '0;
                        wr    <= MEM_W_EN;
                        waddr <= (address - 32'(BASE_ADDR)) >> OFS;
                        wdata <= writeData;
                        be    <= byteEn;
                    end
                S_SETUP: state <= S_STROBE;
                S_STROBE:
                    if (last) begin
                        state <= S_HOLD;
                        if (!wr) rbuf[beat*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                    end
                S_HOLD:
                    if (beat == BW'(BEATS - 1)) begin
                        state <= S_DONE;
                        if (!wr) readData <= rbuf;
                    end else begin
                        state <= S_SETUP;
                        beat  <= beat + 1'b1;
                    end
                default: state <= S_IDLE;
            endcase
        end
    assign SRAM_ADDR = active ? SRAM_AW'(waddr * 32'(BEATS) + 32'(beat)) : '0;
    assign SRAM_DQ   = (active && wr) ? wdata[beat*SRAM_DW +: SRAM_DW] : 'z;
    assign SRAM_CE_N = !active;
    assign SRAM_WE_N = !(state == S_STROBE && wr);
    assign SRAM_OE_N = !(state == S_STROBE && !wr);
    assign SRAM_LB_N = !active || (wr && !lane[0]);
    assign SRAM_UB_N = (LANES == 1) || !active || (wr && !lane[LANES-1]);
`ifdef SRAM_CTRL_POSTED_WRITE_EN
    // A posted write acks on its first setup; its own DONE must not ack a waiting request.
    assign ready = (state == S_IDLE && !req) || (state == S_DONE && !wr) ||
                   (state == S_SETUP && wr && beat == '0);
`else
    assign ready = (state == S_IDLE && !req) || state == S_DONE;
`endif
endmodule

// File: tb/tb_sram_controller_gen.sv
// tb_sram_controller_gen: randomized scoreboard bench with a behavioural SRAM and byte-level memory model
module tb_sram_controller_gen;
    localparam int EXP_LAT = 2 * (2 + 2) + 1;
    localparam int STROBES = 2 * 2;
    logic        clk = 0;
    logic        rst = 0;
    logic        w_en = 0, r_en = 0;
    logic [31:0] address = 0, wdata = 0;
    logic [3:0]  be = 0;
    logic        ready;
    logic [31:0] read_data;
    logic [17:0] sram_addr;
    wire  [15:0] dq;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;
    int          checks = 0, errors = 0;
    bit          mon_en = 0;
    typedef struct { bit rd; logic [31:0] data; } exp_t;
    exp_t        sb[$];
    logic [7:0]  model_b [0:63];
    logic [31:0] last_rd = 0;
    logic [15:0] mem [0:1023];

    sram_controller_gen dut (
        .clk(clk), .rst(rst), .MEM_W_EN(w_en), .MEM_R_EN(r_en), .address(address),
        .writeData(wdata), .byteEn(be), .ready(ready), .readData(read_data),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(dq), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
        .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] iv(input int i);
        return 16'(i * 4951 + 9320);
    endfunction

    assign dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 'z;
    always @(posedge clk)
        if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[9:0]][7:0]  <= dq[7:0];
            if (!ub_n) mem[sram_addr[9:0]][15:8] <= dq[15:8];
        end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        int   n;
        int   wi;
        wi = int'((a - 32'h400) >> 2);
        if (w) begin
            for (int k = 0; k < 4; k++) if (b[k]) model_b[wi*4+k] = d[8*k +: 8];
            e.rd = 0;
        end else begin
            for (int k = 0; k < 4; k++) last_rd[8*k +: 8] = model_b[wi*4+k];
            e.rd = 1;
        end
        e.data = last_rd;
        sb.push_back(e);
        w_en = w; r_en = r; address = a; wdata = d; be = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ready && (w_en || r_en)) && n < 60);
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL txn_timeout: got no ready after %0d cycles, expected ready", n);
        end
        #1 w_en = 0; r_en = 0;
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
        #1;
    endtask

    // Monitor: counts strobes and latency per transaction, pops the scoreboard on each completion.
    int cyc = 0, we_cnt = 0, oe_cnt = 0;
    bit prev_rd = 1;
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            cyc = 0; we_cnt = 0; oe_cnt = 0; prev_rd = 1;
        end else begin
            if (w_en || r_en) cyc++;
            if (!we_n) we_cnt++;
            if (!oe_n) oe_cnt++;
            if (ce_n) chk("dq_idle_z", 64'(dq === 16'hzzzz), 64'd1);
            if (ready && (w_en || r_en)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
                end else begin
                    e = sb.pop_front();
                    chk(e.rd ? "read_data" : "write_keeps_read_data", 64'(read_data), 64'(e.data));
`ifdef SRAM_CTRL_POSTED_WRITE_EN
                    if (!e.rd && prev_rd) chk("posted_write_latency", 64'(cyc), 64'd1);
`else
                    chk("latency", 64'(cyc), 64'(EXP_LAT));
                    chk("we_low_cycles", 64'(we_cnt), e.rd ? 64'd0 : 64'(STROBES));
                    chk("oe_low_cycles", 64'(oe_cnt), e.rd ? 64'(STROBES) : 64'd0);
`endif
                    prev_rd = e.rd;
                end
                cyc = 0; we_cnt = 0; oe_cnt = 0;
            end
        end
    end

    initial begin
        logic [15:0] t;
        for (int i = 0; i < 1024; i++) mem[i] = iv(i);
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 4; k++) begin
                t = iv(2 * w + k / 2);
                model_b[w*4+k] = (k % 2) ? t[15:8] : t[7:0];
            end
        #1;
        chk("reset_strobes", {59'd0, we_n, ce_n, oe_n, ub_n, lb_n}, 64'h1F);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_addr", 64'(sram_addr), 64'd0);
        chk("reset_read_data", 64'(read_data), 64'd0);
        chk("reset_dq_z", 64'(dq === 16'hzzzz), 64'd1);
        repeat (2) @(negedge clk);
        #1 rst = 1; mon_en = 1;
        @(negedge clk); #1;
        txn(1, 0, 32'h400, 32'hDEADBEEF, 4'hF);
        txn(0, 1, 32'h400, 32'h0, 4'h0);
        chk("sram_word0", 64'(mem[0]), 64'h BEEF);
        chk("sram_word1", 64'(mem[1]), 64'h DEAD);
        txn(1, 0, 32'h404, 32'h00AA0000, 4'b0100);
        txn(0, 1, 32'h405, 32'h0, 4'h0);
        t = iv(3);
        chk("lane_beat0_untouched", 64'(mem[2]), 64'(iv(2)));
        chk("lane_beat1_low_only", 64'(mem[3]), 64'({t[15:8], 8'hAA}));
        chk("lane_read_byte2", 64'(read_data[23:16]), 64'hAA);
        txn(1, 1, 32'h408, 32'h0BADF00D, 4'hF);
        txn(0, 1, 32'h408, 32'h0, 4'h0);
        txn(1, 0, 32'h40C, 32'h12345678, 4'hF);
        txn(0, 1, 32'h40C, 32'h0, 4'h0);
        // Reset in the middle of a write strobe
        mon_en = 0;
        w_en = 1; address = 32'h800; wdata = 32'hCAFEF00D; be = 4'hF;
        repeat (3) @(posedge clk);
        #2 chk("mid_write_we_low", 64'(we_n), 64'd0);
        rst = 0;
        #1;
        chk("async_rst_strobes", {59'd0, we_n, ce_n, oe_n, ub_n, lb_n}, 64'h1F);
        chk("async_rst_dq_z", 64'(dq === 16'hzzzz), 64'd1);
        chk("async_rst_read_data", 64'(read_data), 64'd0);
        w_en = 0;
        @(negedge clk); #1 rst = 1;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready), 64'd1);
        chk("post_rst_read_data", 64'(read_data), 64'd0);
        chk("post_rst_addr", 64'(sram_addr), 64'd0);
        #1 last_rd = 0; mon_en = 1;
        @(negedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [31:0] a;
            op = int'($urandom_range(0, 3));
            a  = 32'h400 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            txn(op != 2, op >= 2, a, $urandom, 4'($urandom));
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200us, expected completion");
        $fatal(1);
    end
endmodule
